// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, funct3 op codes, the funct7
// alternate-op marker and the ALU instruction-word builder.
package alu_pkg;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SLL  = 3'd1,
    ALU_SLT  = 3'd2,
    ALU_SLTU = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SR   = 3'd5,
    ALU_OR   = 3'd6,
    ALU_AND  = 3'd7
  } alu_op_e;

  localparam logic [6:0] FUNCT7_ALT = 7'h20;

  // R-type layout with register fields left zero: funct7 in [31:25],
  // funct3 in [14:12].
  function automatic logic [31:0] build_alu_instr(input logic [6:0] funct7,
                                                  input logic [2:0] funct3);
    return {funct7, 10'b0, funct3, 12'b0};
  endfunction

endpackage

// File: rtl/alu.sv
// 64-bit combinational ALU driven by an R-type style instruction word.
// Ports:
//   instr  in   32    instruction word (funct7 [31:25], funct3 [14:12])
//   in1    in   XLEN  operand 1
//   in2    in   XLEN  operand 2 (shift amount taken from in2[5:0])
//   result out  XLEN  ALU result
module alu
  import alu_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic [XLEN-1:0] result
);

  logic       alt;
  logic [5:0] shamt;
  logic       unused_instr;

  assign alt   = instr[30];
  assign shamt = in2[5:0];
  // Only funct3 and funct7[5] select behaviour; the rest of the word is ignored.
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:0]};

  always_comb begin
    result = '0;
    case (alu_op_e'(instr[14:12]))
      ALU_ADD:  result = alt ? (in1 - in2) : (in1 + in2);
      ALU_SLL:  result = in1 << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (in1 < in2)};
      ALU_XOR:  result = in1 ^ in2;
      ALU_SR:   result = alt ? XLEN'($signed(in1) >>> shamt) : (in1 >> shamt);
      ALU_OR:   result = in1 | in2;
      ALU_AND:  result = in1 & in2;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst  in   clock, synchronous active-high reset
//   req0/1    in   request lines
//   advance   in   the current grant was accepted this cycle
//   grant     out  winning requester index (0 or 1)
// A lone requester always wins; on contention rr_ptr decides, and after
// every accept the pointer moves to the other requester.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic grant
);

  logic rr_ptr;

  always_comb begin
    grant = 1'b0;
    if (req0 && req1) grant = rr_ptr;
    else if (req1)    grant = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)          rr_ptr <= 1'b0;
    else if (advance) rr_ptr <= ~grant;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one 64-bit ALU between the execute stage (r0) and the
// address/branch-compare unit (r1), with a one-entry result buffer.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rX_valid / rX_ready           request handshake per requester
//   rX_funct3 / rX_funct7         ALU op select (funct7[5] = SUB/SRA)
//   rX_in1 / rX_in2 / rX_tag      operands and opaque tag
//   res_valid / res_ready         result handshake
//   res_data / res_src / res_tag  result, producing requester, its tag
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [2:0]       r0_funct3,
  input  logic [6:0]       r0_funct7,
  input  logic [XLEN-1:0]  r0_in1,
  input  logic [XLEN-1:0]  r0_in2,
  input  logic [TAG_W-1:0] r0_tag,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [2:0]       r1_funct3,
  input  logic [6:0]       r1_funct7,
  input  logic [XLEN-1:0]  r1_in1,
  input  logic [XLEN-1:0]  r1_in2,
  input  logic [TAG_W-1:0] r1_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [XLEN-1:0]  res_data,
  output logic             res_src,
  output logic [TAG_W-1:0] res_tag
);

  logic             grant;
  logic             can_accept;
  logic             accept;
  logic [2:0]       sel_funct3;
  logic [6:0]       sel_funct7;
  logic [XLEN-1:0]  sel_in1;
  logic [XLEN-1:0]  sel_in2;
  logic [TAG_W-1:0] sel_tag;
  logic [XLEN-1:0]  alu_in2;
  logic [XLEN-1:0]  alu_result;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req0    (r0_valid),
    .req1    (r1_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign can_accept = !res_valid || res_ready;
  assign accept     = !rst && can_accept && (grant ? r1_valid : r0_valid);
  assign r0_ready   = accept && !grant;
  assign r1_ready   = accept && grant;

  always_comb begin
    sel_funct3 = r0_funct3;
    sel_funct7 = r0_funct7;
    sel_in1    = r0_in1;
    sel_in2    = r0_in2;
    sel_tag    = r0_tag;
    if (grant) begin
      sel_funct3 = r1_funct3;
      sel_funct7 = r1_funct7;
      sel_in1    = r1_in1;
      sel_in2    = r1_in2;
      sel_tag    = r1_tag;
    end
  end

  // Shift amounts are 6 bits; clear the rest so stray high bits never reach the ALU.
  always_comb begin
    alu_in2 = sel_in2;
    if (sel_funct3 == ALU_SLL || sel_funct3 == ALU_SR)
      alu_in2 = {{(XLEN-6){1'b0}}, sel_in2[5:0]};
  end

  alu u_alu (
    .instr  (build_alu_instr(sel_funct7, sel_funct3)),
    .in1    (sel_in1),
    .in2    (alu_in2),
    .result (alu_result)
  );

  // A new accept overwrites the buffer even while it is being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_src   <= 1'b0;
      res_tag   <= '0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_data  <= alu_result;
      res_src   <= grant;
      res_tag   <= sel_tag;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [2:0]  r0_funct3, r1_funct3;
  logic [6:0]  r0_funct7, r1_funct7;
  logic [63:0] r0_in1, r0_in2, r1_in1, r1_in2;
  logic [3:0]  r0_tag, r1_tag;
  logic        res_valid, res_ready, res_src;
  logic [63:0] res_data;
  logic [3:0]  res_tag;

  always #5 clk = ~clk;

  alu_share_arbiter #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_funct3(r0_funct3), .r0_funct7(r0_funct7),
    .r0_in1(r0_in1), .r0_in2(r0_in2), .r0_tag(r0_tag),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_funct3(r1_funct3), .r1_funct7(r1_funct7),
    .r1_in1(r1_in1), .r1_in2(r1_in2), .r1_tag(r1_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_src(res_src), .res_tag(res_tag)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: buffer contents and which requester is favoured on contention.
  logic        m_valid, m_src, m_ptr;
  logic [63:0] m_data;
  logic [3:0]  m_tag;
  logic        last_e0, last_e1;

  function automatic logic [63:0] ref_alu(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [63:0] a, input logic [63:0] b);
    int unsigned sh;
    logic        alt;
    sh  = int'(b[5:0]);
    alt = f7[5];
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'd3: return (a < b) ? 64'd1 : 64'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 64'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_r0(input logic v, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [63:0] a, input logic [63:0] b, input logic [3:0] t);
    r0_valid = v; r0_funct3 = f3; r0_funct7 = f7; r0_in1 = a; r0_in2 = b; r0_tag = t;
  endtask

  task automatic set_r1(input logic v, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [63:0] a, input logic [63:0] b, input logic [3:0] t);
    r1_valid = v; r1_funct3 = f3; r1_funct7 = f7; r1_in1 = a; r1_in2 = b; r1_tag = t;
  endtask

  // Inputs are already driven; check mid-cycle, advance the model, cross the edge.
  task automatic step();
    logic g, acc;
    @(negedge clk);
    if (r0_valid && r1_valid) g = m_ptr;
    else                      g = r1_valid;
    acc = !rst && (!m_valid || res_ready) && (g ? r1_valid : r0_valid);
    last_e0 = acc && !g;
    last_e1 = acc && g;
    chk("r0_ready",  {63'b0, r0_ready},  {63'b0, last_e0});
    chk("r1_ready",  {63'b0, r1_ready},  {63'b0, last_e1});
    chk("res_valid", {63'b0, res_valid}, {63'b0, m_valid});
    chk("res_data",  res_data,           m_data);
    chk("res_src",   {63'b0, res_src},   {63'b0, m_src});
    chk("res_tag",   {60'b0, res_tag},   {60'b0, m_tag});
    if (rst) begin
      m_valid = 0; m_data = 0; m_src = 0; m_tag = 0; m_ptr = 0;
    end else if (acc) begin
      m_data  = g ? ref_alu(r1_funct3, r1_funct7, r1_in1, r1_in2)
                  : ref_alu(r0_funct3, r0_funct7, r0_in1, r0_in2);
      m_tag   = g ? r1_tag : r0_tag;
      m_src   = g;
      m_valid = 1;
      m_ptr   = !g;
    end else if (res_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  logic [63:0] saved;

  initial begin
    rst = 1; res_ready = 0;
    set_r0(0, 0, 0, 0, 0, 0);
    set_r1(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    m_valid = 0; m_data = 0; m_src = 0; m_tag = 0; m_ptr = 0;

    // 1/2: reset with r0 pending, then ADD accepted on the first free cycle
    set_r0(1, 3'd0, 7'h00, 64'd5, 64'd7, 4'd3);
    step(); step();
    rst = 0; res_ready = 1;
    step();
    chk("t1_first_accept", {63'b0, last_e0}, 64'd1);
    set_r0(0, 0, 0, 0, 0, 0);
    chk("t2_valid", {63'b0, res_valid}, 64'd1);
    chk("t2_data", res_data, 64'd12);
    chk("t2_src", {63'b0, res_src}, 64'd0);
    chk("t2_tag", {60'b0, res_tag}, 64'd3);

    // 3: r1 arithmetic corners
    set_r1(1, 3'd0, 7'h20, 64'd5, 64'd7, 4'd1); step();
    chk("t3_sub", res_data, 64'hFFFF_FFFF_FFFF_FFFE);
    set_r1(1, 3'd5, 7'h20, 64'h8000_0000_0000_0000, 64'h104, 4'd2); step();
    chk("t3_sra", res_data, 64'hF800_0000_0000_0000);
    set_r1(1, 3'd3, 7'h00, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd3); step();
    chk("t3_sltu", res_data, 64'd1);
    chk("t3_src", {63'b0, res_src}, 64'd1);
    set_r1(0, 0, 0, 0, 0, 0);

    // 4: fairness after reset
    rst = 1; step(); rst = 0;
    set_r0(1, 3'd0, 7'h00, 64'd10, 64'd1, 4'd4);
    set_r1(1, 3'd4, 7'h00, 64'hF0, 64'h0F, 4'd5);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_src", {63'b0, res_src}, 64'(i % 2));
      chk("t4_valid", {63'b0, res_valid}, 64'd1);
    end

    // 5: backpressure holds buffer and blocks both requesters
    res_ready = 0;
    saved = res_data;
    for (int i = 0; i < 3; i++) step();
    chk("t5_hold_data", res_data, saved);
    res_ready = 1;
    step();
    chk("t5_reaccept", {63'b0, last_e0}, 64'd1);
    chk("t5_src", {63'b0, res_src}, 64'd0);

    // 6: reset while holding; pointer (currently at r1) returns to r0
    res_ready = 0;
    rst = 1; step(); rst = 0;
    chk("t6_cleared", {63'b0, res_valid}, 64'd0);
    step();
    chk("t6_first_grant", {63'b0, res_src}, 64'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [63:0] pick[4];
      pick[0] = 64'h8000_0000_0000_0000; pick[1] = 64'hFFFF_FFFF_FFFF_FFFF;
      pick[2] = 64'd0;                   pick[3] = {$urandom, $urandom};
      if (!(r0_valid && !last_e0) || rst)
        set_r0($urandom_range(0, 9) < 6, 3'($urandom), ($urandom_range(0, 1) != 0) ? FUNCT7_ALT : 7'h00,
               pick[$urandom_range(0, 3)], pick[$urandom_range(0, 3)], 4'($urandom));
      if (!(r1_valid && !last_e1) || rst)
        set_r1($urandom_range(0, 9) < 6, 3'($urandom), ($urandom_range(0, 1) != 0) ? FUNCT7_ALT : 7'h00,
               pick[$urandom_range(0, 3)], {$urandom, $urandom}, 4'($urandom));
      res_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 49) == 0;
      step();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
